router_rd_arb: RTL and testbench

ROUTER_RD_ARB -- requirements
Module: router_rd_arb

---
 rtl/router_pkg.sv | 32 +++
 rtl/router_rd_buf.sv | 40 ++++
 rtl/router_rd_arb.sv | 174 +++++++++++++++++
 tb/tb_router_rd_arb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router read-side arbiter: FSM encoding, header
// field positions, port count and the output buffer entry layout.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int ADDR_LSB        = 0;
  localparam int LEN_LSB         = 2;
  localparam int LEN_W           = 6;
  localparam int ABORT_LIMIT_DEF = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BODY  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } buf_entry_t;

  localparam int ENTRY_W = $bits(buf_entry_t);

  // Round-robin successor over ports 0..2.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/router_rd_buf.sv
// Two-entry output buffer with occupancy count; head reads as zero when empty.
module router_rd_buf
  import router_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               valid,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Push and pop together keep the count, even when full.
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid = (count != 2'd0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/router_rd_arb.sv
// Reads whole packets from three router output FIFOs, one port at a time in
// round-robin order, and merges them into one valid/ready byte stream.
module router_rd_arb
  import router_pkg::*;
#(
  parameter int ABORT_LIMIT = ABORT_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_sop,
  output logic       m_eop,
  output logic [1:0] m_port,
  output logic       pkt_abort,
  output logic [1:0] fsm_state
);

  // Handshake: a byte moves downstream on every rising edge where
  // m_valid && m_ready; m_data/m_sop/m_eop/m_port hold while m_valid && !m_ready.

  localparam int SW = $clog2(ABORT_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(ABORT_LIMIT - 1);

  rd_state_t        state, state_nxt;
  logic [1:0]       grant, last_grant, rr_pick;
  logic [3:0]       vld;
  logic             any_vld, vld_g;
  logic             hdr_issued;
  logic [6:0]       remaining;
  logic [SW-1:0]    starve;
  logic             infl, infl_sop, infl_eop;
  logic [1:0]       infl_port;
  logic [7:0]       rd_data;
  logic             pop, space_ok, issue_ok, issue, hdr_back, starved, abort;
  logic [1:0]       buf_count;
  logic [2:0]       occ_sum;
  logic [ENTRY_W-1:0] head_bits;
  buf_entry_t       head_e, push_e;

  assign vld     = {1'b0, vld_out_2, vld_out_1, vld_out_0};
  assign any_vld = |vld;
  assign vld_g   = vld[grant];

  always_comb begin
    rr_pick = next_port(last_grant);
    if (!vld[rr_pick]) begin
      rr_pick = next_port(next_port(last_grant));
      if (!vld[rr_pick]) rr_pick = last_grant;
    end
  end

  always_comb begin
    unique case (infl_port)
      2'd0:    rd_data = data_out_0;
      2'd1:    rd_data = data_out_1;
      2'd2:    rd_data = data_out_2;
      default: rd_data = 8'h00;
    endcase
  end

  // A new read must still fit once every in-flight byte has landed.
  assign occ_sum  = {1'b0, buf_count} + {2'b00, infl} - {2'b00, pop};
  assign space_ok = (occ_sum < 3'd2);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (any_vld) state_nxt = ST_HDR;
      ST_HDR:   if (hdr_back) state_nxt = ST_BODY;
                else if (abort) state_nxt = ST_IDLE;
      ST_BODY:  if (issue && remaining == 7'd1) state_nxt = ST_DRAIN;
                else if (abort) state_nxt = ST_IDLE;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_ok   = vld_g && space_ok && !reset;
    issue      = ((state == ST_HDR) && !hdr_issued && issue_ok) ||
                 ((state == ST_BODY) && (remaining != 7'd0) && issue_ok);
    hdr_back   = (state == ST_HDR) && hdr_issued && infl;
    starved    = !vld_g && (starve == STARVE_LAST);
    abort      = starved && (((state == ST_HDR) && !hdr_back) || (state == ST_BODY));
    read_enb_0 = issue && (grant == 2'd0);
    read_enb_1 = issue && (grant == 2'd1);
    read_enb_2 = issue && (grant == 2'd2);
    fsm_state  = state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant      <= 2'd0;
      last_grant <= 2'd2;
      hdr_issued <= 1'b0;
      remaining  <= 7'd0;
      starve     <= '0;
      infl       <= 1'b0;
      infl_sop   <= 1'b0;
      infl_eop   <= 1'b0;
      infl_port  <= 2'd0;
      pkt_abort  <= 1'b0;
    end else begin
      infl      <= issue;
      pkt_abort <= abort;
      if (issue) begin
        infl_sop  <= (state == ST_HDR);
        infl_eop  <= (state == ST_BODY) && (remaining == 7'd1);
        infl_port <= grant;
      end
      unique case (state)
        ST_IDLE: begin
          if (any_vld) grant <= rr_pick;
          hdr_issued <= 1'b0;
          starve     <= '0;
        end
        ST_HDR, ST_BODY: begin
          starve <= vld_g ? '0 : starve + 1'b1;
          if (issue && state == ST_HDR) hdr_issued <= 1'b1;
          // Remaining counts payload plus the trailing parity byte.
          if (hdr_back) remaining <= {1'b0, rd_data[LEN_LSB +: LEN_W]} + 7'd1;
          if (issue && state == ST_BODY) remaining <= remaining - 7'd1;
          if (abort) last_grant <= grant;
        end
        ST_DRAIN: last_grant <= grant;
        default: ;
      endcase
    end
  end

  always_comb begin
    push_e      = '0;
    push_e.data = rd_data;
    push_e.sop  = infl_sop;
    push_e.eop  = infl_eop;
    push_e.port = infl_port;
  end

  assign pop = m_valid && m_ready;

  router_rd_buf u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (infl),
    .push_data (push_e),
    .pop       (pop),
    .head      (head_bits),
    .valid     (m_valid),
    .count     (buf_count)
  );

  assign head_e = buf_entry_t'(head_bits);
  assign m_data = head_e.data;
  assign m_sop  = head_e.sop;
  assign m_eop  = head_e.eop;
  assign m_port = head_e.port;

endmodule

// File: tb/tb_router_rd_arb.sv
// Directed bench for router_rd_arb: FIFO models for the three router ports,
// an expected byte stream per scenario and a final summary.
module tb_router_rd_arb;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] m_data;
  logic       m_valid, m_ready, m_sop, m_eop, pkt_abort;
  logic [1:0] m_port, fsm_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, abort_cnt, abort_cyc, first_re2, multi_re, rd_tot, acc_tot, max_diff;
  int re_cnt [3];
  logic [7:0]  fq0[$], fq1[$], fq2[$];
  logic [11:0] exp_q[$], out_q[$];
  logic [12:0] last_out;

  router_rd_arb #(.ABORT_LIMIT(25)) dut (
    .clock(clock), .reset(reset),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop),
    .m_eop(m_eop), .m_port(m_port), .pkt_abort(pkt_abort), .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    abort_cnt = 0; abort_cyc = -1; first_re2 = -1; multi_re = 0;
    rd_tot = 0; acc_tot = 0; max_diff = 0;
    for (int i = 0; i < 3; i++) re_cnt[i] = 0;
    out_q.delete(); exp_q.delete();
  endtask

  task automatic push_byte(input logic [1:0] p, input logic [7:0] b);
    case (p)
      2'd0: begin fq0.push_back(b); vld_out_0 = 1'b1; end
      2'd1: begin fq1.push_back(b); vld_out_1 = 1'b1; end
      default: begin fq2.push_back(b); vld_out_2 = 1'b1; end
    endcase
  endtask

  task automatic load_pkt(input logic [1:0] p, input logic [5:0] len, input bit hdr_only);
    logic [7:0] hdr, b, par;
    hdr = {len, p};
    par = hdr;
    push_byte(p, hdr);
    exp_q.push_back({p, 1'b1, 1'b0, hdr});
    if (!hdr_only) begin
      for (int i = 0; i < int'(len); i++) begin
        b = 8'h40 + 8'(p) * 8'h10 + 8'(i);
        par = par ^ b;
        push_byte(p, b);
        exp_q.push_back({p, 1'b0, 1'b0, b});
      end
      push_byte(p, par);
      exp_q.push_back({p, 1'b0, 1'b1, par});
    end
  endtask

  // One clock: sample mid-cycle, then model the FIFO pops on the edge.
  task automatic step();
    logic [2:0] re;
    @(negedge clock);
    re = {read_enb_2, read_enb_1, read_enb_0};
    if ((re & (re - 3'd1)) != 3'd0) multi_re++;
    for (int i = 0; i < 3; i++) if (re[i]) begin re_cnt[i]++; rd_tot++; end
    if (read_enb_2 && first_re2 < 0) first_re2 = cyc;
    if (m_valid && m_ready) begin
      out_q.push_back({m_port, m_sop, m_eop, m_data});
      acc_tot++;
    end
    if (rd_tot - acc_tot > max_diff) max_diff = rd_tot - acc_tot;
    if (pkt_abort) begin abort_cnt++; abort_cyc = cyc; end
    last_out = {m_valid, m_port, m_sop, m_eop, m_data};
    @(posedge clock);
    #1;
    if (re[0] && fq0.size() != 0) data_out_0 = fq0.pop_front();
    if (re[1] && fq1.size() != 0) data_out_1 = fq1.pop_front();
    if (re[2] && fq2.size() != 0) data_out_2 = fq2.pop_front();
    vld_out_0 = (fq0.size() != 0);
    vld_out_1 = (fq1.size() != 0);
    vld_out_2 = (fq2.size() != 0);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; m_ready = 1'b1;
    fq0.delete(); fq1.delete(); fq2.delete();
    vld_out_0 = 1'b0; vld_out_1 = 1'b0; vld_out_2 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    clear_logs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; m_ready = 1'b1; vld_out_0 = 1'b1;
    repeat (2) step();
    @(negedge clock);
    n_cmp++; if ({read_enb_2, read_enb_1, read_enb_0} !== 3'b000) begin n_bad++;
      $display("FAIL reset_read_enb: got %b want 000", {read_enb_2, read_enb_1, read_enb_0}); end
    n_cmp++; if ({m_valid, m_sop, m_eop, pkt_abort} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {m_valid, m_sop, m_eop, pkt_abort}); end
    n_cmp++; if ({m_port, m_data} !== 10'h000) begin n_bad++;
      $display("FAIL reset_data: got %h want 000", {m_port, m_data}); end
    n_cmp++; if (fsm_state !== ST_IDLE) begin n_bad++;
      $display("FAIL reset_state: got %0d want 0", fsm_state); end
  endtask

  task automatic test_single();
    do_reset();
    load_pkt(2'd1, 6'd3, 1'b0);
    repeat (20) step();
    n_cmp++; if (re_cnt[1] !== 5) begin n_bad++;
      $display("FAIL single_reads: got %0d want 5", re_cnt[1]); end
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_bad++;
      $display("FAIL single_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_bad++;
        $display("FAIL single_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    load_pkt(2'd0, 6'd2, 1'b0);
    load_pkt(2'd1, 6'd2, 1'b0);
    load_pkt(2'd2, 6'd2, 1'b0);
    repeat (40) step();
    n_cmp++; if (multi_re !== 0) begin n_bad++;
      $display("FAIL rr_one_read: got %0d want 0", multi_re); end
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_bad++;
      $display("FAIL rr_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_bad++;
        $display("FAIL rr_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] held;
    do_reset();
    load_pkt(2'd0, 6'd6, 1'b0);
    repeat (5) step();
    m_ready = 1'b0;
    step();
    held = last_out;
    repeat (9) step();
    n_cmp++; if (last_out !== held) begin n_bad++;
      $display("FAIL bp_hold: got %h want %h", last_out, held); end
    m_ready = 1'b1;
    repeat (20) step();
    n_cmp++; if (max_diff > 2) begin n_bad++;
      $display("FAIL bp_outstanding: got %0d want <=2", max_diff); end
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_bad++;
      $display("FAIL bp_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_bad++;
        $display("FAIL bp_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    int budget;
    do_reset();
    load_pkt(2'd2, 6'd2, 1'b1);
    budget = 0;
    while (first_re2 < 0 && budget < 10) begin step(); budget++; end
    n_cmp++; if (first_re2 < 0) begin n_bad++;
      $display("FAIL abort_grant2: got none want read_enb_2"); end
    load_pkt(2'd0, 6'd1, 1'b0);
    repeat (45) step();
    n_cmp++; if (abort_cnt !== 1) begin n_bad++;
      $display("FAIL abort_pulses: got %0d want 1", abort_cnt); end
    n_cmp++; if (abort_cyc - first_re2 !== 26) begin n_bad++;
      $display("FAIL abort_delay: got %0d want 26", abort_cyc - first_re2); end
    n_cmp++; if (out_q.size() !== exp_q.size()) begin n_bad++;
      $display("FAIL abort_count: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_bad++;
        $display("FAIL abort_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    load_pkt(2'd0, 6'd0, 1'b0);
    repeat (12) step();
    n_cmp++; if (re_cnt[0] !== 2) begin n_bad++;
      $display("FAIL zero_reads: got %0d want 2", re_cnt[0]); end
    n_cmp++; if (out_q.size() !== 2) begin n_bad++;
      $display("FAIL zero_count: got %0d want 2", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_cmp++; if (out_q[i] !== exp_q[i]) begin n_bad++;
        $display("FAIL zero_byte%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    do_reset();
    load_pkt(2'd1, 6'd5, 1'b0);
    budget = 0;
    while (re_cnt[1] < 3 && budget < 20) begin step(); budget++; end
    n_cmp++; if (fsm_state !== ST_BODY) begin n_bad++;
      $display("FAIL rmid_in_body: got %0d want 2", fsm_state); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    abort_cnt = 0;
    @(negedge clock);
    n_cmp++; if ({read_enb_2, read_enb_1, read_enb_0, m_valid, m_sop, m_eop, pkt_abort} !== 7'b0) begin
      n_bad++;
      $display("FAIL rmid_flags: got %b want 0000000",
               {read_enb_2, read_enb_1, read_enb_0, m_valid, m_sop, m_eop, pkt_abort}); end
    n_cmp++; if ({m_port, m_data} !== 10'h000) begin n_bad++;
      $display("FAIL rmid_data: got %h want 000", {m_port, m_data}); end
    n_cmp++; if (fsm_state !== ST_IDLE) begin n_bad++;
      $display("FAIL rmid_state: got %0d want 0", fsm_state); end
    repeat (3) step();
    n_cmp++; if (abort_cnt !== 0) begin n_bad++;
      $display("FAIL rmid_no_abort: got %0d want 0", abort_cnt); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1; m_ready = 1'b1; cyc = 0;
    vld_out_0 = 1'b0; vld_out_1 = 1'b0; vld_out_2 = 1'b0;
    data_out_0 = 8'h00; data_out_1 = 8'h00; data_out_2 = 8'h00;
    clear_logs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
